// File: rtl/ne_layer_sched_ctrl.sv
// Layer/iteration read scheduler for a layered decoder.
// Reads every row of each layer, drains the row-computer pipeline, then moves on.
module ne_layer_sched_ctrl #(
    parameter int ROWDEPTH       = 20,
    parameter int ROWWIDTH       = 5,
    parameter int LAYERS         = 2,
    parameter int PIPESTAGES     = 13,
    parameter int PIPECOUNTWIDTH = 4,
    parameter int MAXITRS        = 10,
    parameter int ITRWIDTH       = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                loaden,
    input  logic                start,
    output logic                rd_en,
    output logic [ROWWIDTH-1:0] rd_address,
    output logic                rd_layer,
    output logic                rd_last,
    output logic                wr_en,
    output logic [ROWWIDTH-1:0] wr_address,
    output logic                wr_layer,
    output logic                wr_last,
    output logic                first_itr,
    output logic [ITRWIDTH-1:0] itr_count,
    output logic                busy,
    output logic                decoder_ready
);

    // state | meaning
    // IDLE  | waiting for start; Lmem may be loaded
    // READ  | issuing one row read per cycle for the current layer
    // DRAIN | waiting for the last row of the layer to be written back
    // DONE  | decode complete; result may be unloaded
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [ROWWIDTH-1:0]       LAST_ROW   = ROWWIDTH'(ROWDEPTH - 1);
    localparam logic                      LAST_LAYER = 1'(LAYERS - 1);
    localparam logic [ITRWIDTH-1:0]       LAST_ITR   = ITRWIDTH'(MAXITRS - 1);
    localparam logic [PIPECOUNTWIDTH-1:0] DRAIN_INIT = PIPECOUNTWIDTH'(PIPESTAGES - 1);
    localparam int                        DLY_W      = ROWWIDTH + 3;

    state_t                    state;
    state_t                    state_nxt;
    logic [ROWWIDTH-1:0]       addr_nxt;
    logic                      layer_nxt;
    logic [ITRWIDTH-1:0]       itr_nxt;
    logic [PIPECOUNTWIDTH-1:0] drain_cnt;
    logic [PIPECOUNTWIDTH-1:0] drain_nxt;
    logic [DLY_W-1:0]          dly [PIPESTAGES];

    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= IDLE;
            rd_address <= '0;
            rd_layer   <= 1'b0;
            itr_count  <= '0;
            drain_cnt  <= '0;
        end else begin
            state      <= state_nxt;
            rd_address <= addr_nxt;
            rd_layer   <= layer_nxt;
            itr_count  <= itr_nxt;
            drain_cnt  <= drain_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        addr_nxt  = rd_address;
        layer_nxt = rd_layer;
        itr_nxt   = itr_count;
        drain_nxt = drain_cnt;
        unique case (state)
            IDLE, DONE: begin
                // loading new LLRs takes priority over starting a decode
                if (loaden) begin
                    state_nxt = IDLE;
                    addr_nxt  = '0;
                    layer_nxt = 1'b0;
                    itr_nxt   = '0;
                end else if (start) begin
                    state_nxt = READ;
                    addr_nxt  = '0;
                    layer_nxt = 1'b0;
                    itr_nxt   = '0;
                end
            end
            READ: begin
                if (rd_address == LAST_ROW) begin
                    state_nxt = DRAIN;
                    addr_nxt  = '0;
                    drain_nxt = DRAIN_INIT;
                end else begin
                    addr_nxt = rd_address + ROWWIDTH'(1);
                end
            end
            DRAIN: begin
                // final drain cycle coincides with the layer's last write-back
                if (drain_cnt == '0) begin
                    if (rd_layer != LAST_LAYER) begin
                        state_nxt = READ;
                        layer_nxt = rd_layer + 1'b1;
                    end else if (itr_count != LAST_ITR) begin
                        state_nxt = READ;
                        layer_nxt = 1'b0;
                        itr_nxt   = itr_count + ITRWIDTH'(1);
                    end else begin
                        state_nxt = DONE;
                        layer_nxt = 1'b0;
                    end
                end else begin
                    drain_nxt = drain_cnt - PIPECOUNTWIDTH'(1);
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign rd_en         = (state == READ);
    assign rd_last       = rd_en && (rd_address == LAST_ROW);
    assign busy          = (state == READ) || (state == DRAIN);
    assign first_itr     = busy && (itr_count == '0);
    assign decoder_ready = (state == DONE);

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < PIPESTAGES; i++) dly[i] <= '0;
        end else begin
            dly[0] <= {rd_en, rd_address, rd_layer, rd_last};
            for (int i = 1; i < PIPESTAGES; i++) dly[i] <= dly[i-1];
        end
    end

    assign {wr_en, wr_address, wr_layer, wr_last} = dly[PIPESTAGES-1];

endmodule

// File: tb/tb_ne_layer_sched_ctrl.sv
// Directed bench for ne_layer_sched_ctrl: cycle model of the read schedule
// plus a queue of expected write-backs due PIPESTAGES cycles after each read.
module tb_ne_layer_sched_ctrl;

    localparam int ROWDEPTH = 20;
    localparam int PIPE     = 13;
    localparam int LAYCYC   = ROWDEPTH + PIPE;
    localparam int ITRCYC   = LAYCYC * 2;
    localparam int TOTAL    = ITRCYC * 10;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       loaden = 1'b0;
    logic       start = 1'b0;
    logic       rd_en, rd_layer, rd_last, wr_en, wr_layer, wr_last;
    logic       first_itr, busy, decoder_ready;
    logic [4:0] rd_address, wr_address;
    logic [3:0] itr_count;

    ne_layer_sched_ctrl dut (
        .clk(clk), .rst(rst), .loaden(loaden), .start(start),
        .rd_en(rd_en), .rd_address(rd_address), .rd_layer(rd_layer), .rd_last(rd_last),
        .wr_en(wr_en), .wr_address(wr_address), .wr_layer(wr_layer), .wr_last(wr_last),
        .first_itr(first_itr), .itr_count(itr_count), .busy(busy),
        .decoder_ready(decoder_ready)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         due;
        logic [4:0] addr;
        logic       layer;
        logic       last;
    } sb_t;

    sb_t sb[$];
    int  n_assert = 0;
    int  n_fail = 0;
    int  cyc = 0;
    int  t0 = 0;
    bit  dec_active = 0;
    bit  exp_ready = 0;
    bit  chk_itr = 1;
    int  cnt_rd, cnt_wr, cnt_rdlast, cnt_wrlast;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // advance one clock, then compare every output against the model
    task automatic step();
        int         t, p;
        logic       e_rd, e_last, e_lay, e_busy, e_first, e_wr;
        logic [4:0] e_addr;
        int         e_itr;
        sb_t        ent;
        @(posedge clk);
        #1;
        cyc++;
        e_rd = 0; e_last = 0; e_lay = 0; e_busy = 0; e_first = 0; e_addr = '0; e_itr = 0;
        if (dec_active) begin
            t = cyc - t0;
            if (t > TOTAL) begin
                dec_active = 0;
                exp_ready  = 1;
                chk_itr    = 0;
            end else begin
                p       = (t - 1) % LAYCYC;
                e_lay   = 1'(((t - 1) / LAYCYC) % 2);
                e_itr   = (t - 1) / ITRCYC;
                e_rd    = (p < ROWDEPTH);
                e_addr  = e_rd ? 5'(p) : 5'd0;
                e_last  = (p == ROWDEPTH - 1);
                e_busy  = 1;
                e_first = (e_itr == 0);
            end
        end
        check("rd_en", 32'(rd_en), 32'(e_rd));
        check("rd_address", 32'(rd_address), 32'(e_addr));
        check("rd_layer", 32'(rd_layer), 32'(e_lay));
        check("rd_last", 32'(rd_last), 32'(e_last));
        check("busy", 32'(busy), 32'(e_busy));
        check("first_itr", 32'(first_itr), 32'(e_first));
        check("decoder_ready", 32'(decoder_ready), 32'(exp_ready));
        if (dec_active || chk_itr) check("itr_count", 32'(itr_count), 32'(e_itr));
        if (e_rd) sb.push_back('{cyc + PIPE, e_addr, e_lay, e_last});
        e_wr = (sb.size() > 0) && (sb[0].due == cyc);
        check("wr_en", 32'(wr_en), 32'(e_wr));
        if (e_wr) begin
            ent = sb.pop_front();
            check("wr_address", 32'(wr_address), 32'(ent.addr));
            check("wr_layer", 32'(wr_layer), 32'(ent.layer));
            check("wr_last", 32'(wr_last), 32'(ent.last));
        end
        if (rd_en) cnt_rd++;
        if (wr_en) cnt_wr++;
        if (rd_last) cnt_rdlast++;
        if (wr_last) cnt_wrlast++;
    endtask

    task automatic kick_start();
        start      = 1;
        t0         = cyc;
        dec_active = 1;
        exp_ready  = 0;
        step();
        start      = 0;
    endtask

    initial begin
        // reset: everything, including the write-side delay line, reads zero
        repeat (3) step();
        check("rst_wr_address", 32'(wr_address), 32'd0);
        check("rst_wr_layer", 32'(wr_layer), 32'd0);
        check("rst_wr_last", 32'(wr_last), 32'd0);
        rst = 1;
        step();

        // start together with loaden in IDLE: stays idle
        start = 1; loaden = 1;
        step();
        start = 0; loaden = 0;
        repeat (3) step();

        // full decode, with start+loaden pulsed mid-decode (ignored while busy)
        cnt_rd = 0; cnt_wr = 0; cnt_rdlast = 0; cnt_wrlast = 0;
        start = 1; t0 = cyc; dec_active = 1; exp_ready = 0;
        for (int k = 1; k <= TOTAL + 3; k++) begin
            if (k == 40 || k == 300) begin start = 1; loaden = 1; end
            step();
            start = 0; loaden = 0;
        end
        check("rd_en_total", 32'(cnt_rd), 32'd400);
        check("wr_en_total", 32'(cnt_wr), 32'd400);
        check("rd_last_total", 32'(cnt_rdlast), 32'd20);
        check("wr_last_total", 32'(cnt_wrlast), 32'd20);

        // loaden in DONE returns to IDLE and drops decoder_ready
        loaden = 1; exp_ready = 0;
        step();
        loaden = 0;
        repeat (2) step();

        // abort with reset during layer 1 of iteration 3
        kick_start();
        for (int k = 2; k <= 3 * ITRCYC + LAYCYC + 5; k++) step();
        rst = 0; dec_active = 0; sb.delete(); chk_itr = 1; exp_ready = 0;
        step();
        check("abort_wr_address", 32'(wr_address), 32'd0);
        check("abort_wr_layer", 32'(wr_layer), 32'd0);
        check("abort_wr_last", 32'(wr_last), 32'd0);
        rst = 1;
        cnt_wr = 0;
        repeat (30) step();
        check("abort_no_wr", 32'(cnt_wr), 32'd0);

        // restart from iteration 0, run to DONE, then restart directly from DONE
        kick_start();
        for (int k = 2; k <= TOTAL + 2; k++) step();
        kick_start();
        for (int k = 2; k <= 80; k++) step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/ne_layer_sched_ctrl.md
NE_LAYER_SCHED_CTRL -- requirements
Module: ne_layer_sched_ctrl

Interface
REQ-001 Parameter ROWDEPTH, default 20, meaning address rows per layer (ceil(Z/P)=ceil(511/26)).
REQ-002 Parameter ROWWIDTH, default 5, meaning width of row address.
REQ-003 Parameter LAYERS, default 2, meaning layers per iteration.
REQ-004 Parameter PIPESTAGES, default 13, meaning read-to-write latency of the row computer (memory read plus 12 RCU stages).
REQ-005 Parameter PIPECOUNTWIDTH, default 4, meaning drain counter width.
REQ-006 Parameter MAXITRS, default 10, meaning decoding iterations per codeword.
REQ-007 Parameter ITRWIDTH, default 4, meaning iteration counter width.
REQ-008 Port clk, input, 1, meaning the single clock; all logic is on its rising edge.
REQ-009 Port rst, input, 1, meaning reset; synchronous, active-low.
REQ-010 Port loaden, input, 1, meaning the input interface is writing channel LLRs into Lmem.
REQ-011 Port start, input, 1, meaning a one-cycle pulse that begins decoding.
REQ-012 Port rd_en, output, 1, meaning a row read is issued this cycle.
REQ-013 Port rd_address, output, ROWWIDTH, meaning the row read address.
REQ-014 Port rd_layer, output, 1, meaning the layer of the read.
REQ-015 Port rd_last, output, 1, meaning the read row is ROWDEPTH-1 (only P_LAST=17 valid lanes).
REQ-016 Port wr_en, wr_address, wr_layer, wr_last, outputs, 1/ROWWIDTH/1/1, meaning the read-side signals delayed by PIPESTAGES.
REQ-017 Port first_itr, output, 1, meaning the current iteration is 0; the RCU treats Emem read data as zero.
REQ-018 Port itr_count, output, ITRWIDTH, meaning the current iteration index.
REQ-019 Port busy, output, 1, meaning the state is READ or DRAIN.
REQ-020 Port decoder_ready, output, 1, meaning decoding is complete and the result may be unloaded.

Function
REQ-021 The FSM SHALL have states IDLE, READ, DRAIN and DONE.
REQ-022 In IDLE or DONE, start=1 with loaden=0 SHALL enter READ on the next cycle with rd_address=0, rd_layer=0 and itr_count=0.
REQ-023 In IDLE or DONE, loaden=1 SHALL win over start; it stays in or returns to IDLE and clears decoder_ready.
REQ-024 start and loaden SHALL be ignored while busy=1.
REQ-025 In READ, rd_en SHALL be 1 every cycle, and rd_address SHALL count 0..ROWDEPTH-1 one step per cycle with no gaps.
REQ-026 After the cycle with rd_address=ROWDEPTH-1, the FSM SHALL enter DRAIN for exactly PIPESTAGES cycles with rd_en=0.
  - The last write of the layer coincides with the final DRAIN cycle, so the next layer reads updated LLRs (no RAW hazard).
REQ-027 At the end of DRAIN, if rd_layer<LAYERS-1, the FSM SHALL return to READ with rd_layer+1 and rd_address=0.
REQ-028 At the end of DRAIN, else if itr_count<MAXITRS-1, the FSM SHALL return to READ with rd_layer=0 and itr_count+1.
REQ-029 At the end of DRAIN, else the FSM SHALL go to DONE, and decoder_ready SHALL rise the same cycle DONE is entered and hold until loaden or start.
REQ-030 The write side SHALL be a PIPESTAGES-deep shift register of {rd_en, rd_address, rd_layer, rd_last}, cleared on reset; wr_* are its output.
REQ-031 rd_last SHALL equal rd_en AND (rd_address==ROWDEPTH-1).
REQ-032 first_itr SHALL equal (itr_count==0) while busy=1, and 0 otherwise.
REQ-033 Cycles per layer SHALL be ROWDEPTH+PIPESTAGES=33; cycles per codeword SHALL be 33*LAYERS*MAXITRS=660 from the first READ cycle to DONE.
REQ-034 rd_address SHALL hold 0 outside READ.

Reset
REQ-035 rst=0 at a clock edge SHALL force IDLE with all outputs at 0 (rd_*, wr_*, itr_count, first_itr, busy, decoder_ready) and the delay line cleared.
REQ-036 Reset applied mid-decode SHALL abort the decode with no further wr_en pulses; a new start is required afterwards.

Verification
REQ-037 Reset then start pulse -> rd_en high cycles 1..20 with addresses 0..19 on layer 0; wr_en high cycles 14..33 with addresses 0..19; rd_en resumes at cycle 34 on layer 1.
REQ-038 Full decode -> 20 rd_en pulses per layer, 400 in total; decoder_ready rises at cycle 661 after start; first_itr high only during cycles 1..66.
REQ-039 rd_last and wr_last -> high exactly once per layer, at rd_address=19 and 13 cycles later at wr_address=19.
REQ-040 start while busy, and start together with loaden in IDLE -> no effect on sequencing; in the loaden case the FSM stays in IDLE.
REQ-041 rst=0 during layer 1 of iteration 3 -> all outputs 0 on the next cycle, no wr_en thereafter; a following start restarts from itr_count=0, layer 0.
REQ-042 Scoreboard over a full decode -> every wr_address/wr_layer pair equals the rd pair issued exactly 13 cycles earlier.
